alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-byte arithmetic sequencer for the 8-bit ALU datapath (ADD/SUB/AND/OR with carry-in, zero/carry/negative flags).
- Accepts one WORDS-byte operation over a valid/ready request, drives the external ALU one byte per cycle LSB-first, chains carry and returns the full-width result plus aggregate flags over a valid/ready response.
- Sits beside one ALU instance in the datapath top level; it owns all ALU inputs.

Parameters:
- WORDS, 4, operand width in bytes (legal 1..16); operand width N = 8*WORDS.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- req_a  in  N  operand A
- req_b  in  N  operand B
- req_cin  in  1  carry-in; used by ADD only
- alu_fun  out  2  ALU function select
- alu_a  out  8  ALU operand byte A
- alu_b  out  8  ALU operand byte B
- alu_cin  out  1  ALU carry-in
- alu_out  in  8  ALU result byte
- alu_cout  in  1  ALU carry-out
- alu_zero  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  N  result
- rsp_cout  out  1  final carry (SUB: 1 = no borrow); 0 for AND/OR
- rsp_zero  out  1  1 when all N result bits are 0
- rsp_neg  out  1  rsp_data[N-1]

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=0 at an edge, any state including mid-RUN): state IDLE, byte index 0, carry 0, rsp_data 0, rsp_cout/rsp_zero/rsp_neg 0, rsp_valid 0. An in-flight operation is discarded.
- Outputs:
  - req_ready = (state==IDLE), combinational from state.
  - rsp_valid = (state==DONE).
- IDLE:
  - On req_valid && req_ready, latch op, A and B.
  - Latch initial carry: ADD = req_cin, SUB = 1, AND/OR = 0.
  - Set zero accumulator to 1 and index to 0; go to RUN.
- RUN, per cycle, index i:
  - alu_a = A byte i.
  - alu_b = B byte i, inverted for SUB.
  - alu_fun = 00 for ADD and SUB; 10 for AND; 11 for OR.
  - alu_cin = carry register.
  - At the edge:
    - result byte i <= alu_out.
    - carry <= alu_cout for ADD/SUB, else 0.
    - zero accumulator &= alu_zero.
  - At i==WORDS-1, go to DONE.
  - The ALU is combinational; there is exactly one byte per cycle and no stall.
- Latency: rsp_valid rises on the WORDS-th edge after the accepting edge (WORDS=1: next edge).
- DONE:
  - rsp_* are held stable until rsp_valid && rsp_ready, then go to IDLE.
  - rsp_ready asserted in the same cycle as rsp_valid rises completes in one cycle.
  - No new request is accepted while in RUN or DONE; req_valid is ignored there.
  - No back-to-back overlap: minimum request spacing is WORDS+1 cycles.
- ALU drive outside RUN: alu_fun=00, alu_a=0, alu_b=0, alu_cin=0.
- SUB semantics: A + ~B + 1 modulo 2^N. rsp_cout=1 iff A >= B (unsigned).
- rsp_neg is the sign bit of the final byte (alu_neg in the last RUN cycle).
- Index counter width: $clog2(WORDS)+1; it never wraps within an operation.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - Extra output port rsp_ovf (1 bit) gives the signed overflow of ADD/SUB.
  - Formula: carry into bit N-1 XOR final carry out.
  - Carry into bit N-1 is derived in the last RUN cycle as alu_out[7] ^ alu_a[7] ^ alu_b[7].
  - rsp_ovf is 0 for AND/OR, 0 at reset, and held with the other rsp_* signals.
- Undefined: no rsp_ovf port and no related logic.

Decomposition:
- Package alu_seq_pkg holds:
  - op enum: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - ALU function constants: FUN_ADD=2'b00, FUN_AND=2'b10, FUN_OR=2'b11.
  - state enum: IDLE, RUN, DONE.
- No sub-module: byte select and result insertion are inline indexed part-selects.
- The ALU instance lives in the enclosing top, not inside this block.

Test Plan (WORDS=4, ALU instance attached):
- ADD 0x000000FF + 0x00000001, cin 0 -> rsp_data 0x00000100, cout 0, zero 0, neg 0; rsp_valid exactly 4 edges after accept.
- ADD 0xFFFFFFFF + 0x00000001 -> rsp_data 0x00000000, cout 1, zero 1, neg 0. Also ADD 1 + 1 with cin 1 -> 0x00000003.
- SUB 0x00000000 - 0x00000001 -> rsp_data 0xFFFFFFFF, cout 0, neg 1. Also SUB 0x00001000 - 0x00000001 -> 0x00000FFF, cout 1.
- AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0, cout 0. OR 0x80000000 | 0x00000001 -> 0x80000001, neg 1.
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> rsp_* stable, req_ready=0, second request not accepted until the cycle after the handshake.
- Reset asserted after 2 RUN cycles -> next edge: req_ready=1, rsp_valid=0, all rsp_* 0. With ALU_SEQ_OVF_EN: ADD 0x7FFFFFFF + 1 -> rsp_ovf 1, neg 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types and constants for the multi-byte ALU sequencer.
//   op_e    : request operation codes as they appear on req_op
//   FUN_*   : function-select codes understood by the 8-bit ALU
//   state_e : sequencer state encoding
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_AND = 2'b10;
  localparam logic [1:0] FUN_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Sequences one WORDS-byte ADD/SUB/AND/OR through an external 8-bit
// combinational ALU, one byte per cycle LSB-first, chaining the carry, and
// returns the full-width result with aggregate carry/zero/negative flags.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b,
//   req_cin                    operation, N-bit operands, carry-in (ADD only)
//   alu_fun, alu_a, alu_b,
//   alu_cin                    drive to the external ALU
//   alu_out, alu_cout,
//   alu_zero, alu_neg          result byte and flags from the ALU
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_cout,
//   rsp_zero, rsp_neg          N-bit result and aggregate flags
//   rsp_ovf                    signed overflow of ADD/SUB (only with
//                              ALU_SEQ_OVF_EN defined)
//
// Build option: define ALU_SEQ_OVF_EN to add the rsp_ovf output.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [8*WORDS-1:0] req_a,
  input  logic [8*WORDS-1:0] req_b,
  input  logic               req_cin,
  output logic [1:0]         alu_fun,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic               alu_cin,
  input  logic [7:0]         alu_out,
  input  logic               alu_cout,
  input  logic               alu_zero,
  input  logic               alu_neg,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [8*WORDS-1:0] rsp_data,
  output logic               rsp_cout,
  output logic               rsp_zero,
  output logic               rsp_neg
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic               rsp_ovf
`endif
);

  localparam int N  = 8 * WORDS;
  localparam int IW = $clog2(WORDS) + 1;
  localparam int SW = $clog2(N);

  state_e           state_q;
  op_e              op_q;
  logic [N-1:0]     opA_q;
  logic [N-1:0]     opB_q;
  logic [N-1:0]     result_q;
  logic             carry_q;
  logic             zeroAcc_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic             rspCout_q;
  logic             rspZero_q;
  logic             rspNeg_q;
  logic [SW-1:0]    bitBase;
  logic             isArith;
  logic             lastByte;

  // Bit offset of the current byte; idx_q never exceeds WORDS-1 while it is
  // used, so dropping the top bits in the cast loses nothing.
  assign bitBase  = SW'({idx_q, 3'b000});
  assign idx_d    = idx_q + IW'(1);
  assign isArith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign lastByte = (idx_q == IW'(WORDS - 1));

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = result_q;
  assign rsp_cout  = rspCout_q;
  assign rsp_zero  = rspZero_q;
  assign rsp_neg   = rspNeg_q;

  // ALU drive: quiet zeros outside RUN. Subtraction is A + ~B + 1, so the
  // B byte is inverted and the carry register was preset to 1 on accept.
  always_comb begin
    alu_fun = FUN_ADD;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = opA_q[bitBase +: 8];
      alu_b   = (op_q == OP_SUB) ? ~opB_q[bitBase +: 8] : opB_q[bitBase +: 8];
      alu_cin = carry_q;
      case (op_q)
        OP_AND:  alu_fun = FUN_AND;
        OP_OR:   alu_fun = FUN_OR;
        default: alu_fun = FUN_ADD;
      endcase
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic rspOvf_q;
  logic carryIntoMsb;

  // Carry into the top result bit, recovered from the sum bit and its inputs.
  assign carryIntoMsb = alu_out[7] ^ alu_a[7] ^ alu_b[7];
  assign rsp_ovf      = rspOvf_q;

  // Overflow flag is captured alongside the other response flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rspOvf_q <= 1'b0;
    end else if (state_q == RUN && lastByte) begin
      rspOvf_q <= isArith ? (carryIntoMsb ^ alu_cout) : 1'b0;
    end
  end
`endif

  // Sequencer FSM: accept in IDLE, one ALU byte per cycle in RUN, hold the
  // response in DONE until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      opA_q     <= '0;
      opB_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zeroAcc_q <= 1'b0;
      idx_q     <= '0;
      rspCout_q <= 1'b0;
      rspZero_q <= 1'b0;
      rspNeg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            opA_q     <= req_a;
            opB_q     <= req_b;
            zeroAcc_q <= 1'b1;
            idx_q     <= '0;
            state_q   <= RUN;
            case (op_e'(req_op))
              OP_ADD:  carry_q <= req_cin;
              OP_SUB:  carry_q <= 1'b1;
              default: carry_q <= 1'b0;
            endcase
          end
        end
        RUN: begin
          result_q[bitBase +: 8] <= alu_out;
          carry_q                <= isArith ? alu_cout : 1'b0;
          zeroAcc_q              <= zeroAcc_q & alu_zero;
          if (lastByte) begin
            rspCout_q <= isArith ? alu_cout : 1'b0;
            rspZero_q <= zeroAcc_q & alu_zero;
            rspNeg_q  <= alu_neg;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Bench for alu_seq_ctrl with WORDS=4 and a behavioural 8-bit ALU attached.
// Directed table vectors, hand-written backpressure and mid-operation reset
// sequences, and random operations checked against a full-width model.
// Build option: ALU_SEQ_OVF_EN adds the rsp_ovf checks.
module tb_alu_seq_ctrl;

  localparam int WORDS = 4;
  localparam int N     = 8 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         req_cin;
  logic [1:0]   alu_fun;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_out;
  logic         alu_cout;
  logic         alu_zero;
  logic         alu_neg;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         rsp_neg;
`ifdef ALU_SEQ_OVF_EN
  logic         rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] data;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
  } vec_t;

  alu_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .alu_fun   (alu_fun),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero),
    .alu_neg   (alu_neg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg)
`ifdef ALU_SEQ_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The external 8-bit combinational ALU.
  logic [8:0] aluSum;
  always_comb begin
    aluSum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_cin};
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    case (alu_fun)
      2'b00: begin
        alu_out  = aluSum[7:0];
        alu_cout = aluSum[8];
      end
      2'b10:   alu_out = alu_a & alu_b;
      2'b11:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_out == 8'h00);
    alu_neg  = alu_out[7];
  end

  // Full-width reference: plain N-bit arithmetic on whole operands.
  function automatic vec_t model(input logic [1:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic cin);
    vec_t       v;
    logic [N:0] s;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.cin  = cin;
    v.cout = 1'b0;
    v.ovf  = 1'b0;
    case (op)
      2'b00: begin
        s      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        v.data = s[N-1:0];
        v.cout = s[N];
        v.ovf  = (a[N-1] == b[N-1]) && (v.data[N-1] != a[N-1]);
      end
      2'b01: begin
        v.data = a - b;
        v.cout = (a >= b);
        v.ovf  = (a[N-1] != b[N-1]) && (v.data[N-1] != a[N-1]);
      end
      2'b10:   v.data = a & b;
      default: v.data = a | b;
    endcase
    v.zero = (v.data == '0);
    v.neg  = v.data[N-1];
    return v;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic cin,
                              input logic [N-1:0] data, input logic cout,
                              input logic zero, input logic neg, input logic ovf);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin;
    v.data = data; v.cout = cout; v.zero = zero; v.neg = neg; v.ovf = ovf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_cin   = v.cin;
  endtask

  // Waits (bounded) for rsp_valid; lat counts edges after the accepting one.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
    end
  endtask

  task automatic checkResult(input vec_t v, input string tag);
    checkOutput({tag, " data"}, 64'(rsp_data), 64'(v.data));
    checkOutput({tag, " cout"}, 64'(rsp_cout), 64'(v.cout));
    checkOutput({tag, " zero"}, 64'(rsp_zero), 64'(v.zero));
    checkOutput({tag, " neg"},  64'(rsp_neg),  64'(v.neg));
`ifdef ALU_SEQ_OVF_EN
    checkOutput({tag, " ovf"},  64'(rsp_ovf),  64'(v.ovf));
`endif
  endtask

  // One full operation starting from a negedge in IDLE, ending at a negedge
  // just after the response handshake.
  task automatic runOp(input vec_t v, input int hold, input bit keepValid,
                       input string tag);
    int lat;
    checkOutput({tag, " req_ready"}, 64'(req_ready), 64'(1));
    applyStimulus(v);
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = keepValid;
    waitRsp(lat);
    checkOutput({tag, " latency"}, 64'(lat), 64'(WORDS));
    checkResult(v, tag);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput({tag, " hold"},
                  64'({rsp_valid, req_ready, rsp_data, rsp_cout, rsp_zero, rsp_neg}),
                  64'({1'b1, 1'b0, v.data, v.cout, v.zero, v.neg}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, " release"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
  endtask

  vec_t tbl[9];
  vec_t v;
  int   lat;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    tbl[0] = mk(2'b00, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(2'b00, 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3] = mk(2'b01, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(2'b01, 32'h00001000, 32'h00000001, 1'b0, 32'h00000FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[5] = mk(2'b10, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6] = mk(2'b11, 32'h80000000, 32'h00000001, 1'b1, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[7] = mk(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
    tbl[8] = mk(2'b01, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Power-on reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready/valid", 64'({req_ready, rsp_valid}), 64'(2'b10));
    checkOutput("reset rsp", 64'({rsp_data, rsp_cout, rsp_zero, rsp_neg}), 64'(0));
    checkOutput("reset alu drive", 64'({alu_fun, alu_a, alu_b, alu_cin}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      runOp(tbl[i], i % 3, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure with a second request waiting the whole time.
    v = model(2'b00, 32'h01020304, 32'h10203040, 1'b1);
    runOp(v, 3, 1'b1, "bp");
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("bp second accepted", 64'(req_ready), 64'(0));
    waitRsp(lat);
    checkOutput("bp second latency", 64'(lat), 64'(WORDS));
    checkResult(v, "bp second");
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset after two RUN cycles discards the operation.
    applyStimulus(model(2'b00, 32'h12345678, 32'h11111111, 1'b0));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrun reset ready/valid", 64'({req_ready, rsp_valid}), 64'(2'b10));
    checkOutput("midrun reset rsp", 64'({rsp_data, rsp_cout, rsp_zero, rsp_neg}), 64'(0));
`ifdef ALU_SEQ_OVF_EN
    checkOutput("midrun reset ovf", 64'(rsp_ovf), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Random operations against the full-width model.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      v  = model(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
      runOp(v, $urandom_range(0, 2), 1'b0, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
